// File: rtl/alu_serial_rx.sv
// Serial command receiver for the ALU core: deserialises 11-bit packets into
// {B, A, op}, checks framing/count/CRC/opcode, and queues frames in an output FIFO.
module alu_serial_rx #(
    parameter int OP_BYTES   = 4,
    parameter int FIFO_DEPTH = 2,
    parameter int TIMEOUT    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*OP_BYTES-1:0] out_b,
    output logic [8*OP_BYTES-1:0] out_a,
    output logic [2:0]            out_op,
    output logic [2:0]            out_err,
    output logic                  ovf,
    output logic                  busy
);
    localparam int DW   = 8 * OP_BYTES;
    localparam int NPKT = 2 * OP_BYTES;
    localparam int EW   = 2 * DW + 6;
    localparam int PW   = $clog2(NPKT + 1);
    localparam int TW   = $clog2(TIMEOUT + 1);
    localparam int CW   = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RX     = 2'd1;
    localparam logic [1:0] S_GAP    = 2'd2;
    localparam logic [1:0] S_RESYNC = 2'd3;

    // One serial step of the x^4+x+1 CRC.
    function automatic logic [3:0] crc4_step(input logic [3:0] crc, input logic b);
        logic fb;
        fb = b ^ crc[3];
        return {crc[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
    endfunction

    function automatic logic op_legal(input logic [2:0] op);
        logic ok;
        case (op)
            3'b000, 3'b001, 3'b100, 3'b101: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

    logic [1:0]           state_q, state_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [PW-1:0]        pkt_cnt_q, pkt_cnt_d;
    logic [TW-1:0]        idle_cnt_q, idle_cnt_d;
    logic [7:0]           shreg_q, shreg_d;
    logic                 ptype_q, ptype_d;
    logic [3:0]           crc_q, crc_d;
    logic [2*DW-1:0]      data_q, data_d;
    logic [FIFO_DEPTH*EW-1:0] mem_q, mem_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 out_valid_q, out_valid_d;
    logic                 ovf_q, ovf_d;
    logic                 busy_q, busy_d;

    logic                 push_s;
    logic [EW-1:0]        push_entry_s;
    logic [EW-1:0]        err_entry_s;
    logic [2:0]           rx_op_s;
    logic [2:0]           chk_err_s;

    assign err_entry_s = {3'b100, 3'b000, {(2*DW){1'b0}}};
    assign rx_op_s     = shreg_q[6:4];
    assign chk_err_s   = {1'b0, (crc_q != shreg_q[3:0]), ~op_legal(rx_op_s)};

    // Receive FSM: bit/packet sequencing, CRC accumulation and frame hand-off.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        pkt_cnt_d    = pkt_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        shreg_d      = shreg_q;
        ptype_d      = ptype_q;
        crc_d        = crc_q;
        data_d       = data_q;
        push_s       = 1'b0;
        push_entry_s = err_entry_s;
        case (state_q)
            S_IDLE: begin
                if (!sin) begin
                    state_d   = S_RX;
                    bit_cnt_d = 4'd1;
                    pkt_cnt_d = '0;
                    crc_d     = 4'h0;
                    data_d    = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RX: begin
                if (bit_cnt_q == 4'd10) begin
                    bit_cnt_d = 4'd0;
                    if (!sin) begin
                        push_s  = 1'b1;
                        state_d = S_RESYNC;
                    end else if (!ptype_q) begin
                        if (pkt_cnt_q == PW'(NPKT)) begin
                            push_s  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            data_d     = {data_q[2*DW-9:0], shreg_q};
                            pkt_cnt_d  = pkt_cnt_q + PW'(1);
                            idle_cnt_d = '0;
                            state_d    = S_GAP;
                        end
                    end else begin
                        push_s  = 1'b1;
                        state_d = S_IDLE;
                        if (pkt_cnt_q == PW'(NPKT)) begin
                            push_entry_s = {chk_err_s, rx_op_s, data_q};
                        end else begin
                            push_entry_s = err_entry_s;
                        end
                    end
                end else begin
                    shreg_d   = {shreg_q[6:0], sin};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    // The cmd type bit itself is the '1' that precedes op in the CRC stream.
                    if (bit_cnt_q == 4'd1) begin
                        ptype_d = sin;
                        crc_d   = sin ? crc4_step(crc_q, 1'b1) : crc_q;
                    end else if (!ptype_q || (bit_cnt_q >= 4'd3 && bit_cnt_q <= 4'd5)) begin
                        crc_d = crc4_step(crc_q, sin);
                    end else begin
                        crc_d = crc_q;
                    end
                end
            end
            S_GAP: begin
                if (!sin) begin
                    state_d   = S_RX;
                    bit_cnt_d = 4'd1;
                end else if (idle_cnt_q == TW'(TIMEOUT)) begin
                    push_s  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    idle_cnt_d = idle_cnt_q + TW'(1);
                end
            end
            S_RESYNC: begin
                if (sin) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RESYNC;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    logic                     pop_s;
    logic                     full_s;
    logic                     wr_s;
    logic [CW-1:0]            cnt_pop_s;
    logic [FIFO_DEPTH*EW-1:0] base_s;

    // Shift-register FIFO: slot 0 is always the head, so outputs come straight from flops.
    always_comb begin
        pop_s     = out_valid_q && out_ready;
        full_s    = (cnt_q == CW'(FIFO_DEPTH));
        cnt_pop_s = pop_s ? (cnt_q - CW'(1)) : cnt_q;
        wr_s      = push_s && (!full_s || pop_s);
        base_s    = pop_s ? (mem_q >> EW) : mem_q;
        mem_d     = base_s;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (wr_s && (CW'(i) == cnt_pop_s)) begin
                mem_d[i*EW +: EW] = push_entry_s;
            end else begin
                mem_d[i*EW +: EW] = base_s[i*EW +: EW];
            end
        end
        cnt_d       = wr_s ? (cnt_pop_s + CW'(1)) : cnt_pop_s;
        out_valid_d = (cnt_d != '0);
        ovf_d       = ovf_q | (push_s && full_s && !pop_s);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= 4'd0;
            pkt_cnt_q   <= '0;
            idle_cnt_q  <= '0;
            shreg_q     <= 8'h00;
            ptype_q     <= 1'b0;
            crc_q       <= 4'h0;
            data_q      <= '0;
            mem_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            pkt_cnt_q   <= pkt_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            shreg_q     <= shreg_d;
            ptype_q     <= ptype_d;
            crc_q       <= crc_d;
            data_q      <= data_d;
            mem_q       <= mem_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_a     = mem_q[DW-1:0];
    assign out_b     = mem_q[2*DW-1:DW];
    assign out_op    = mem_q[2*DW+2:2*DW];
    assign out_err   = mem_q[2*DW+5:2*DW+3];
    assign ovf       = ovf_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_alu_serial_rx.sv
// Directed bench for alu_serial_rx: table of hand-computed frames plus
// sequences for reset, bad packet counts, timeout, framing error and FIFO fill.
module tb_alu_serial_rx;
    localparam int TO = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sin = 1'b1;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] out_b;
    logic [31:0] out_a;
    logic [2:0]  out_op;
    logic [2:0]  out_err;
    logic        ovf;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    alu_serial_rx #(.OP_BYTES(4), .FIFO_DEPTH(2), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .sin(sin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_b(out_b), .out_a(out_a), .out_op(out_op), .out_err(out_err),
        .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] b;
        logic [31:0] a;
        logic [2:0]  op;
        logic [3:0]  crc;
        logic [2:0]  exp_err;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        sin = b;
    endtask

    task automatic send_pkt(input logic t, input logic [7:0] p, input logic stop, input logic rdy);
        send_bit(1'b0);
        send_bit(t);
        for (int i = 7; i >= 0; i--) send_bit(p[i]);
        send_bit(stop);
        if (rdy) out_ready = 1'b1;
    endtask

    task automatic send_frame(input logic [31:0] b, input logic [31:0] a,
                              input logic [2:0] op, input logic [3:0] crc, input logic rdy);
        for (int i = 3; i >= 0; i--) send_pkt(1'b0, b[i*8 +: 8], 1'b1, 1'b0);
        for (int i = 3; i >= 0; i--) send_pkt(1'b0, a[i*8 +: 8], 1'b1, 1'b0);
        send_pkt(1'b1, {1'b0, op, crc}, 1'b1, rdy);
    endtask

    task automatic check_err_frame(input string name);
        check({name, "_valid"}, 64'(out_valid), 64'd1);
        check({name, "_err"},   64'(out_err),   64'd4);
        check({name, "_a"},     64'(out_a),     64'd0);
        check({name, "_b"},     64'(out_b),     64'd0);
        check({name, "_op"},    64'(out_op),    64'd0);
    endtask

    task automatic drain_one(input string name);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, "_drained"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        vecs[0] = '{32'h0, 32'h0, 3'b000, 4'b1011, 3'b000};
        vecs[1] = '{32'h0, 32'h0, 3'b100, 4'b0000, 3'b010};
        vecs[2] = '{32'h0, 32'h0, 3'b010, 4'b1101, 3'b001};
        vecs[3] = '{32'h0, 32'h0, 3'b101, 4'b0100, 3'b000};
        vecs[4] = '{32'h0, 32'h0, 3'b001, 4'b1000, 3'b000};
        vecs[5] = '{32'h0, 32'h0, 3'b111, 4'b0000, 3'b011};
        vecs[6] = '{32'h1, 32'h0, 3'b000, 4'b1100, 3'b000};
        vecs[7] = '{32'h0, 32'h1, 3'b000, 4'b1110, 3'b000};
        vecs[8] = '{32'h0, 32'h2, 3'b000, 4'b0001, 3'b000};
        vecs[9] = '{32'h0, 32'h3, 3'b000, 4'b0100, 3'b000};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_err",   64'(out_err),   64'd0);
        check("rst_ovf",   64'(ovf),       64'd0);
        check("rst_busy",  64'(busy),      64'd0);
        rst_n = 1'b1;

        // Reset mid-stream with a frame already queued
        send_frame(32'h0, 32'h0, 3'b000, 4'b1011, 1'b0);
        send_pkt(1'b0, 8'h12, 1'b1, 1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        check("mid_busy",  64'(busy),      64'd1);
        check("mid_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_busy",  64'(busy),      64'd0);
        check("midrst_a",     64'(out_a),     64'd0);
        @(negedge clk);
        sin   = 1'b1;
        rst_n = 1'b1;

        // Table of complete frames
        for (int k = 0; k < 10; k++) begin
            send_frame(vecs[k].b, vecs[k].a, vecs[k].op, vecs[k].crc, 1'b0);
            check($sformatf("v%0d_early", k), 64'(out_valid), 64'd0);
            @(negedge clk);
            check($sformatf("v%0d_valid", k), 64'(out_valid), 64'd1);
            check($sformatf("v%0d_err", k),   64'(out_err),   64'(vecs[k].exp_err));
            check($sformatf("v%0d_op", k),    64'(out_op),    64'(vecs[k].op));
            check($sformatf("v%0d_a", k),     64'(out_a),     64'(vecs[k].a));
            check($sformatf("v%0d_b", k),     64'(out_b),     64'(vecs[k].b));
            check($sformatf("v%0d_busy", k),  64'(busy),      64'd0);
            drain_one($sformatf("v%0d", k));
        end

        // Cmd after 7 data packets
        for (int i = 0; i < 7; i++) send_pkt(1'b0, 8'hFF, 1'b1, 1'b0);
        send_pkt(1'b1, 8'h0B, 1'b1, 1'b0);
        @(negedge clk);
        check_err_frame("short");
        drain_one("short");

        // Nine data packets
        for (int i = 0; i < 9; i++) send_pkt(1'b0, 8'hFF, 1'b1, 1'b0);
        @(negedge clk);
        check_err_frame("long");
        check("long_busy", 64'(busy), 64'd0);
        drain_one("long");

        // Inter-packet timeout
        for (int i = 0; i < 4; i++) send_pkt(1'b0, 8'hA5, 1'b1, 1'b0);
        repeat (TO + 1) @(negedge clk);
        check("to_before_valid", 64'(out_valid), 64'd0);
        check("to_before_busy",  64'(busy),      64'd1);
        @(negedge clk);
        check_err_frame("to");
        check("to_busy", 64'(busy), 64'd0);
        drain_one("to");

        // Framing error then resync
        send_pkt(1'b0, 8'h55, 1'b0, 1'b0);
        @(negedge clk);
        check_err_frame("frm");
        check("frm_busy", 64'(busy), 64'd1);
        sin       = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("frm_idle_busy", 64'(busy),      64'd0);
        check("frm_drained",   64'(out_valid), 64'd0);

        // Push while full with a simultaneous pop
        send_frame(32'h0, 32'h1, 3'b000, 4'b1110, 1'b0);
        send_frame(32'h0, 32'h2, 3'b000, 4'b0001, 1'b0);
        send_frame(32'h0, 32'h3, 3'b000, 4'b0100, 1'b1);
        @(negedge clk);
        check("pp_a0",   64'(out_a), 64'd2);
        check("pp_ovf",  64'(ovf),   64'd0);
        @(negedge clk);
        check("pp_a1",   64'(out_a), 64'd3);
        check("pp_v1",   64'(out_valid), 64'd1);
        @(negedge clk);
        check("pp_empty", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        // Overflow: third frame dropped, first two delivered in order
        send_frame(32'h0, 32'h1, 3'b000, 4'b1110, 1'b0);
        send_frame(32'h0, 32'h2, 3'b000, 4'b0001, 1'b0);
        send_frame(32'h0, 32'h3, 3'b000, 4'b0100, 1'b0);
        @(negedge clk);
        check("ovf_set",   64'(ovf),       64'd1);
        check("ovf_valid", 64'(out_valid), 64'd1);
        check("ovf_a0",    64'(out_a),     64'd1);
        @(negedge clk);
        check("ovf_hold",  64'(out_a),     64'd1);
        out_ready = 1'b1;
        @(negedge clk);
        check("ovf_a1",    64'(out_a),     64'd2);
        check("ovf_v1",    64'(out_valid), 64'd1);
        @(negedge clk);
        check("ovf_empty", 64'(out_valid), 64'd0);
        check("ovf_sticky", 64'(ovf),      64'd1);
        out_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/alu_serial_rx.md
Name: alu_serial_rx

Overview:
- Parametrised serial-frame receiver that sits in front of the ALU core.
- Deserialises the 11-bit-packet ALU command protocol from `sin` and assembles operands A and B plus the opcode.
- Checks framing, packet count, CRC and opcode.
- Delivers each frame, with its error flags, through a FIFO and a valid/ready handshake.
- Generalises the fixed 32-bit receiver in two ways: operand width is set by OP_BYTES, and it adds output buffering, an inter-packet timeout and an overflow flag.

Parameters:
OP_BYTES, 4, bytes per operand; each operand is 8*OP_BYTES bits and a frame carries 2*OP_BYTES data packets.
FIFO_DEPTH, 2, number of completed frames buffered at the output (>=1).
TIMEOUT, 32, maximum idle cycles allowed between packets inside a frame.

Ports:
clk  in  1  clock; reset rst_n, asynchronous, active-low; clock clk
rst_n  in  1  asynchronous active-low reset
sin  in  1  serial input; idles high; sampled on posedge clk, one bit per cycle
out_valid  out  1  FIFO head holds a frame
out_ready  in  1  consumer accepts the head frame when out_valid && out_ready at posedge
out_b  out  8*OP_BYTES  operand B
out_a  out  8*OP_BYTES  operand A
out_op  out  3  opcode
out_err  out  3  {err_data, err_crc, err_op}
ovf  out  1  sticky: a completed frame was dropped because the FIFO was full
busy  out  1  high while a frame is partially received

Behaviour:
- Reset: all outputs 0; FSM goes to IDLE; FIFO emptied; counters, shift register and CRC cleared. Reset mid-packet discards the partial frame.
- Packet format, MSB first: start bit 0, type bit (0 = data, 1 = cmd), 8 payload bits, stop bit 1.
- Frame order: B bytes (MS byte first), then A bytes (MS byte first), then one cmd packet with payload {1'b0, op[2:0], crc[3:0]}.
- FSM states:
  - IDLE: sin=0 starts a packet → RX; bit counter=1, packet counter=0.
  - RX: shifts bits 1..10. When stop bit sampled (bit 10):
    - stop=0 → framing error → RESYNC.
    - Data packet with count < 2*OP_BYTES → store byte, count+1, → GAP.
    - Data packet with count = 2*OP_BYTES → err_data frame → IDLE.
    - Cmd packet with count != 2*OP_BYTES → err_data frame → IDLE.
    - Cmd packet with count = 2*OP_BYTES → checked frame → IDLE.
  - GAP: sin=0 → RX. Idle counter exceeding TIMEOUT → err_data frame → IDLE.
  - RESYNC: push err_data frame; wait for sin=1 → IDLE.
- busy = 1 in RX, GAP and RESYNC whenever at least one packet or bit of the frame has been received.
- CRC: 4-bit, polynomial x^4+x+1, initial value 0. Serial update per bit: fb = bit ^ crc[3]; crc = {crc[2:0],1'b0} ^ (fb ? 4'b0011 : 0). Computed over {B, A, 1'b1, op}, i.e. 16*OP_BYTES+4 bits.
- Checked frame flags:
  - err_crc = received crc != computed crc.
  - err_op = op not in {000 AND, 001 OR, 100 ADD, 101 SUB}.
  - Both flags may be set together. A, B and op are delivered as received.
- err_data frames: out_err = 3'b100; out_a, out_b and out_op are 0.
- Frame push happens on the same edge that samples the deciding bit (stop bit, timeout expiry or framing error). out_valid rises in the next cycle.
- FIFO:
  - Delivery is in order; the head is held stable while out_valid && !out_ready.
  - If the FIFO is full at push time, the frame is dropped and ovf is set; ovf is cleared only by rst_n.
  - A simultaneous pop and push while full succeeds (no drop).
- A packet starting in the cycle immediately after a stop bit is legal (zero gap).

Test Plan:
1. Assert rst_n=0 mid-stream → all outputs 0, FIFO empty; the first frame after release is received cleanly.
2. OP_BYTES=4, A=B=0, op=000, cmd payload 8'b0000_1011 → one cycle after the stop bit: out_valid=1, out_err=000, out_op=000.
3. A=B=0, op=100, cmd payload 8'b0100_0000 (correct crc is 0111) → out_err=010, out_op=100.
4. A=B=0, op=010, cmd payload 8'b0010_1101 (correct crc) → out_err=001.
5. Cmd packet after 7 data packets → out_err=100, out_a=out_b=0. Separately: 4 data packets, then sin high for TIMEOUT+1 cycles → one err_data frame, busy returns to 0.
6. out_ready=0, three good frames with A=1,2,3 → ovf=1, frames A=1 and A=2 retained. Then out_ready=1 → delivered A=1 then A=2 on consecutive cycles, then out_valid=0.
